mips_datapath_param: RTL and testbench
======================================

Name: mips_datapath_param

Overview:
- Next-generation multicycle MIPS datapath, parametrised in data/address width (8/16/32).
- Adds synchronous reset and an internal instruction-fetch sequencer, which replaces the external per-byte IR write enables.
- Adds a req/ready memory handshake with automatic stall, so memory is external to the block.
- Sits between the existing multicycle controller (op/funct/zero out, control strobes in) and a shared instruction/data memory. Reuses the existing register_file, alu and mux2/mux3/mux4 modules.

Parameters:
- DATA_WIDTH, 8, datapath, register and address width; legal values 8, 16, 32.
- NBEATS, 32/DATA_WIDTH, derived (localparam): memory beats per instruction fetch.
- STEP, DATA_WIDTH/8, derived (localparam): byte-address increment per fetch beat.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pcen  in  1  PC load enable (gated by stall).
- iord  in  1  address select: 0 = PC, 1 = ALU result.
- memread  in  1  data read request.
- memwrite  in  1  data write request.
- irfetch  in  1  one-cycle pulse; starts an instruction fetch at the current PC.
- regdst, memtoreg, regwrite, alusrca  in  1 each  as in the 8-bit datapath.
- alusrcb  in  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alucont  in  3  ALU operation.
- pcsource  in  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- mem_addr  out  DATA_WIDTH  byte address.
- mem_wdata  out  DATA_WIDTH  store data (B register).
- mem_req  out  1  access request.
- mem_we  out  1  write qualifier.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes this cycle.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- zero  out  1  ALU zero flag.
- fetch_busy  out  1  fetch sequencer active.
- fetch_done  out  1  one-cycle pulse when IR is complete.
- stall  out  1  data access pending without ready.

Behaviour:
- Reset (synchronous, active-high): PC, IR, MDR, A, B, ALUOut, beat counter, fetch FSM → 0/IDLE. Outputs after reset: op=0, funct=0, fetch_busy=0, fetch_done=0, mem_req=0, stall=0.
- Register-file contents are not reset.
- Fetch FSM states:
  - IDLE: on irfetch, go to FETCH with beat=0.
  - FETCH: on each beat with mem_ready=1, write mem_rdata into IR[beat*DATA_WIDTH +: DATA_WIDTH] (lowest lane first) and increment beat. When the last beat (NBEATS-1) completes, go to DONE.
  - DONE: pulse fetch_done for one cycle, then go to IDLE.
  - The FSM holds FETCH indefinitely while mem_ready=0.
- Fetch addressing: mem_addr = PC + beat*STEP, mem_req=1, mem_we=0. PC is not modified by the fetch. The controller advances PC by 4 afterwards via alusrcb=01 with pcen.
- irfetch while busy is ignored. If memread/memwrite is asserted during FETCH, fetch has priority and the data request waits.
- Data access (fetch_busy=0):
  - mem_req = memread|memwrite, mem_we = memwrite, mem_addr = iord ? ALU result : PC.
  - stall = mem_req & ~mem_ready.
  - While stalled, PC, A, B, ALUOut, MDR and register-file writes are all frozen (pcen and regwrite are internally masked).
  - MDR captures mem_rdata only on a memread cycle with mem_ready=1.
- Non-stalled cycles: A/B load from rd1/rd2 and ALUOut loads from the ALU result every cycle.
- Immediate handling: imm = sign-extend instr[15:0], truncated to DATA_WIDTH. immx4 = imm<<2, truncated.
- Jump target: {instr[25:0],2'b00}, truncated to DATA_WIDTH (zero-extended if wider).
- All arithmetic is modulo 2^DATA_WIDTH; the PC wraps silently at the top of the address space.
- Reset asserted mid-fetch or mid-stall: FSM returns to IDLE next edge, partial IR is cleared, mem_req drops.
- op/funct are driven combinationally from the IR.

Decomposition:
- Shared package: fetch FSM state encoding (IDLE/FETCH/DONE); alusrcb and pcsource encodings; constant 4; legal DATA_WIDTH check.
- Sub-module: ir_fetch_seq, which holds the FSM, beat counter, IR lane writes and fetch_done.
- Datapath flops, muxes and stall gating stay in the top level.

Test Plan:
- DATA_WIDTH=8, PC=0x10, memory bytes 0x10..0x13 = 0x20,0x00,0x01,0x8C, mem_ready=1, irfetch pulse → addresses 0x10,0x11,0x12,0x13 on 4 consecutive cycles; fetch_done pulses; op=0x23, funct=0x20; PC still 0x10.
- DATA_WIDTH=32, same fetch → single beat at addr 0x10; IR=0x8C010020; fetch_done one cycle after the beat.
- DATA_WIDTH=8 fetch with mem_ready low for 3 cycles on beat 2 → fetch_busy held; mem_addr stays 0x12; IR lane 2 written only when ready returns; total 7 beat cycles.
- memread with iord=1, ALU result=0x40, mem_ready=0 for 2 cycles then data 0x5A → stall=1 for 2 cycles; pcen/regwrite ignored during stall; MDR=0x5A after the ready edge.
- Reset asserted on beat 1 of an 8-bit fetch → next cycle fetch_busy=0, mem_req=0, IR=0, PC=0, op=0.
- PC=0xFE (8-bit), alusrca=0, alusrcb=01, alucont=add, pcen=1 → PC wraps to 0x02; zero=0.

Source files
------------

// File: rtl/mips_datapath_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mips_datapath_param_pkg                                         |
// | Desc   : Shared encodings and width check for the parametric datapath.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package mips_datapath_param_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DONE  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMX4 = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam int c_PC_INCR = 4;

    function automatic bit legal_data_width(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_datapath_param_ir_fetch_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ir_fetch_seq                                                    |
// | Desc   : Multi-beat instruction fetch; assembles IR lowest lane first.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ir_fetch_seq
    import mips_datapath_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  irfetch_i,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [1:0]            beat_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           ir_o
);

    localparam int         NBEATS      = 32 / DATA_WIDTH;
    localparam logic [1:0] c_LAST_BEAT = 2'(NBEATS - 1);

    fetch_state_e state_q;
    logic [1:0]   beat_q;
    logic         busy_q;
    logic         done_q;
    logic [31:0]  ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
            beat_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ir_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                FS_IDLE: begin
                    if (irfetch_i) begin
                        state_q <= FS_FETCH;
                        beat_q  <= 2'd0;
                        busy_q  <= 1'b1;
                    end
                end
                FS_FETCH: begin
                    if (mem_ready_i) begin
                        for (int l = 0; l < NBEATS; l++) begin
                            if (beat_q == 2'(l)) begin
                                ir_q[l*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_i;
                            end
                        end
                        if (beat_q == c_LAST_BEAT) begin
                            state_q <= FS_DONE;
                            beat_q  <= 2'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                FS_DONE: state_q <= FS_IDLE;
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    assign beat_o = beat_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign ir_o   = ir_q;

endmodule
`default_nettype wire

// File: rtl/mips_datapath_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mips_datapath_param                                             |
// | Desc   : Multicycle MIPS datapath with internal fetch and mem handshake. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mips_datapath_param
    import mips_datapath_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcen,
    input  logic                  iord,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  irfetch,
    input  logic                  regdst,
    input  logic                  memtoreg,
    input  logic                  regwrite,
    input  logic                  alusrca,
    input  logic [1:0]            alusrcb,
    input  logic [2:0]            alucont,
    input  logic [1:0]            pcsource,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [5:0]            op,
    output logic [5:0]            funct,
    output logic                  zero,
    output logic                  fetch_busy,
    output logic                  fetch_done,
    output logic                  stall
);

    localparam int STEP = DATA_WIDTH / 8;

    if (!legal_data_width(DATA_WIDTH)) begin : g_width_check
        $error("mips_datapath_param: DATA_WIDTH must be 8, 16 or 32");
    end

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0] a_q, b_q, aluout_q;
    logic [DATA_WIDTH-1:0] rf_q [32];

    logic [31:0]           w_instr;
    logic [1:0]            w_beat;
    logic                  w_data_req;
    logic                  w_mdr_load;
    logic                  w_rf_we;
    logic [4:0]            w_ra1, w_ra2, w_wa;
    logic [DATA_WIDTH-1:0] w_rd1, w_rd2, w_wd;
    logic [DATA_WIDTH-1:0] w_imm, w_immx4, w_jump;
    logic [DATA_WIDTH-1:0] w_srca, w_srcb, w_alu_result, w_next_pc;

    ir_fetch_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fetch (
        .clk         (clk),
        .reset       (reset),
        .irfetch_i   (irfetch),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata),
        .beat_o      (w_beat),
        .busy_o      (fetch_busy),
        .done_o      (fetch_done),
        .ir_o        (w_instr)
    );

    assign op    = w_instr[31:26];
    assign funct = w_instr[5:0];

    // Casting the full-width expressions truncates (or zero-extends the jump)
    assign w_imm   = DATA_WIDTH'({{16{w_instr[15]}}, w_instr[15:0]});
    assign w_immx4 = DATA_WIDTH'({{14{w_instr[15]}}, w_instr[15:0], 2'b00});
    assign w_jump  = DATA_WIDTH'({w_instr[25:0], 2'b00});

    // A data request raised during a fetch waits, holding the datapath with it
    assign w_data_req = memread | memwrite;
    assign stall      = w_data_req & (fetch_busy | ~mem_ready);
    assign mem_req    = fetch_busy | w_data_req;
    assign mem_we     = ~fetch_busy & memwrite;
    assign mem_wdata  = b_q;
    assign mem_addr   = fetch_busy ? (pc_q + DATA_WIDTH'(w_beat * STEP))
                      : (iord ? w_alu_result : pc_q);

    assign w_ra1   = w_instr[25:21];
    assign w_ra2   = w_instr[20:16];
    assign w_wa    = regdst ? w_instr[15:11] : w_instr[20:16];
    assign w_wd    = memtoreg ? mdr_q : aluout_q;
    assign w_rf_we = regwrite & ~stall;
    assign w_rd1   = (w_ra1 == 5'd0) ? '0 : rf_q[w_ra1];
    assign w_rd2   = (w_ra2 == 5'd0) ? '0 : rf_q[w_ra2];

    always_ff @(posedge clk) begin
        if (w_rf_we && (w_wa != 5'd0)) begin
            rf_q[w_wa] <= w_wd;
        end
    end

    assign w_srca = alusrca ? a_q : pc_q;

    always_comb begin
        case (alusrcb)
            c_SRCB_B:    w_srcb = b_q;
            c_SRCB_FOUR: w_srcb = DATA_WIDTH'(c_PC_INCR);
            c_SRCB_IMM:  w_srcb = w_imm;
            default:     w_srcb = w_immx4;
        endcase
    end

    always_comb begin
        case (alucont)
            c_ALU_AND: w_alu_result = w_srca & w_srcb;
            c_ALU_OR:  w_alu_result = w_srca | w_srcb;
            c_ALU_SUB: w_alu_result = w_srca - w_srcb;
            c_ALU_SLT: w_alu_result = DATA_WIDTH'($signed(w_srca) < $signed(w_srcb));
            default:   w_alu_result = w_srca + w_srcb;
        endcase
    end

    assign zero = (w_alu_result == '0);

    always_comb begin
        case (pcsource)
            c_PCSRC_ALUOUT: w_next_pc = aluout_q;
            c_PCSRC_JUMP:   w_next_pc = w_jump;
            default:        w_next_pc = w_alu_result;
        endcase
    end

    // The fetch owns mem_ready while busy, so MDR only listens when idle
    assign w_mdr_load = memread & mem_ready & ~fetch_busy;

    always_comb begin
        pc_d  = (pcen && !stall) ? w_next_pc : pc_q;
        mdr_d = w_mdr_load ? mem_rdata : mdr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else if (!stall) begin
            pc_q     <= pc_d;
            mdr_q    <= mdr_d;
            a_q      <= w_rd1;
            b_q      <= w_rd2;
            aluout_q <= w_alu_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_datapath_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_mips_datapath_param                                          |
// | Desc   : Directed self-checking bench, 8-bit and 32-bit instances.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_mips_datapath_param;

    logic       clk;
    logic       reset, pcen, iord, memread, memwrite, irfetch;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucont;

    logic [7:0]  addr8, wdata8, rdata8;
    logic        req8, we8, rdy8, zero8, busy8, done8, stall8;
    logic [5:0]  op8, funct8;
    logic [31:0] addr32, wdata32, rdata32;
    logic        req32, we32, rdy32, zero32, busy32, done32, stall32;
    logic [5:0]  op32, funct32;

    logic [7:0] mem [256];
    int         n_tests, n_fail, nbusy;

    assign rdata8  = mem[addr8];
    assign rdata32 = {mem[addr32[7:0] + 8'd3], mem[addr32[7:0] + 8'd2],
                      mem[addr32[7:0] + 8'd1], mem[addr32[7:0]]};

    mips_datapath_param #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .pcen(pcen), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irfetch(irfetch), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
        .pcsource(pcsource), .mem_addr(addr8), .mem_wdata(wdata8), .mem_req(req8),
        .mem_we(we8), .mem_rdata(rdata8), .mem_ready(rdy8), .op(op8), .funct(funct8),
        .zero(zero8), .fetch_busy(busy8), .fetch_done(done8), .stall(stall8)
    );

    mips_datapath_param #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .pcen(pcen), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irfetch(irfetch), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
        .pcsource(pcsource), .mem_addr(addr32), .mem_wdata(wdata32), .mem_req(req32),
        .mem_we(we32), .mem_rdata(rdata32), .mem_ready(rdy32), .op(op32), .funct(funct32),
        .zero(zero32), .fetch_busy(busy32), .fetch_done(done32), .stall(stall32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Pulses irfetch and waits (bounded) for the 8-bit fetch to complete
    task automatic fetch_and_wait(input string tag);
        irfetch = 1'b1;
        next_cycle();
        irfetch = 1'b0;
        for (int k = 0; k < 12; k++) begin
            sample();
            if (done8) break;
            next_cycle();
        end
        check(tag, {31'd0, done8}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h20; mem[8'h11] = 8'h00; mem[8'h12] = 8'h01; mem[8'h13] = 8'h8C;
        mem[8'h00] = 8'hFE; mem[8'h40] = 8'h5A;
        {pcen, iord, memread, memwrite, irfetch} = '0;
        {regdst, memtoreg, regwrite, alusrca} = '0;
        alusrcb = 2'b00; pcsource = 2'b00; alucont = 3'b010;
        rdy8 = 1'b1; rdy32 = 1'b1;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        sample();
        check("rst_op",    {26'd0, op8},    32'd0);
        check("rst_funct", {26'd0, funct8}, 32'd0);
        check("rst_busy",  {31'd0, busy8},  32'd0);
        check("rst_done",  {31'd0, done8},  32'd0);
        check("rst_req",   {31'd0, req8},   32'd0);
        check("rst_stall", {31'd0, stall8}, 32'd0);
        check("rst_pc",    {24'd0, addr8},  32'd0);

        // Walk PC to 0x10 with four PC+4 steps
        pcen = 1'b1; alusrcb = 2'b01;
        repeat (4) next_cycle();
        pcen = 1'b0; alusrcb = 2'b00;
        sample();
        check("pc_setup8",  {24'd0, addr8}, 32'h10);
        check("pc_setup32", addr32,         32'h10);

        // Clean fetch: 4 beats on the 8-bit path, 1 beat on the 32-bit path
        irfetch = 1'b1;
        next_cycle();
        irfetch = 1'b0;
        for (int b = 0; b < 4; b++) begin
            sample();
            check($sformatf("fetch_addr%0d", b), {24'd0, addr8}, 32'h10 + 32'(b));
            check($sformatf("fetch_req%0d", b),  {30'd0, req8, we8}, 32'b10);
            check($sformatf("fetch_busy%0d", b), {31'd0, busy8}, 32'd1);
            if (b == 0) begin
                check("f32_addr", addr32,          32'h10);
                check("f32_busy", {31'd0, busy32}, 32'd1);
            end
            if (b == 1) begin
                check("f32_done", {31'd0, done32}, 32'd1);
                check("f32_ir",   dut32.u_fetch.ir_q, 32'h8C010020);
            end
            next_cycle();
        end
        sample();
        check("f8_done",  {31'd0, done8},  32'd1);
        check("f8_busy",  {31'd0, busy8},  32'd0);
        check("f8_op",    {26'd0, op8},    32'h23);
        check("f8_funct", {26'd0, funct8}, 32'h20);
        check("f8_ir",    dut8.u_fetch.ir_q, 32'h8C010020);
        next_cycle();
        sample();
        check("f8_done_pulse", {31'd0, done8}, 32'd0);
        check("f8_pc_kept",    {24'd0, addr8}, 32'h10);

        // Fetch with mem_ready low for three cycles on beat 2
        mem[8'h12] = 8'h41;
        irfetch = 1'b1;
        next_cycle();
        irfetch = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            rdy8 = !(k >= 2 && k <= 4);
            sample();
            if (!busy8) break;
            nbusy++;
            if (k >= 2 && k <= 4) check($sformatf("wait_addr%0d", k), {24'd0, addr8}, 32'h12);
            if (k == 4) check("wait_lane2_old", {24'd0, dut8.u_fetch.ir_q[23:16]}, 32'h01);
            next_cycle();
        end
        rdy8 = 1'b1;
        check("wait_beats", nbusy, 32'd7);
        check("wait_ir",    dut8.u_fetch.ir_q, 32'h8C410020);
        check("wait_done",  {31'd0, done8}, 32'd1);
        next_cycle();

        // Reset asserted on beat 1
        irfetch = 1'b1;
        next_cycle();
        irfetch = 1'b0;
        next_cycle();
        sample();
        check("mid_beat1_addr", {24'd0, addr8}, 32'h11);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        sample();
        check("mid_busy",  {31'd0, busy8},  32'd0);
        check("mid_req",   {31'd0, req8},   32'd0);
        check("mid_ir",    dut8.u_fetch.ir_q, 32'd0);
        check("mid_op",    {26'd0, op8},    32'd0);
        check("mid_funct", {26'd0, funct8}, 32'd0);
        check("mid_pc",    {24'd0, addr8},  32'd0);

        // PC wrap: PC = 0 + imm(0xFE), then +4 wraps to 0x02 on 8 bits
        fetch_and_wait("wrap_fetch_done");
        pcen = 1'b1; alusrcb = 2'b10;
        next_cycle();
        alusrcb = 2'b01; iord = 1'b1;
        sample();
        check("wrap_alu8",  {24'd0, addr8}, 32'h02);
        check("wrap_zero8", {31'd0, zero8}, 32'd0);
        check("wrap_alu32", addr32,         32'h102);
        next_cycle();
        pcen = 1'b0; iord = 1'b0; alusrcb = 2'b00; alucont = 3'b000;
        sample();
        check("wrap_pc8",   {24'd0, addr8}, 32'h02);
        check("wrap_pc32",  addr32,         32'h102);
        check("and_zero8",  {31'd0, zero8}, 32'd1);
        alucont = 3'b010;

        // Data read at ALU result 0x40 with two not-ready cycles
        mem[8'h00] = 8'h40;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        fetch_and_wait("rd_fetch_done");
        memread = 1'b1; iord = 1'b1; alusrcb = 2'b10; pcen = 1'b1; regwrite = 1'b1;
        rdy8 = 1'b0;
        #1;
        check("rd_stall0", {31'd0, stall8}, 32'd1);
        check("rd_addr0",  {24'd0, addr8},  32'h40);
        check("rd_req0",   {30'd0, req8, we8}, 32'b10);
        next_cycle();
        sample();
        check("rd_stall1",  {31'd0, stall8}, 32'd1);
        check("rd_addr1",   {24'd0, addr8},  32'h40);
        check("rd_mdr_hold", {24'd0, dut8.mdr_q}, 32'h00);
        rdy8 = 1'b1; pcen = 1'b0; regwrite = 1'b0;
        #1;
        check("rd_stall_off", {31'd0, stall8}, 32'd0);
        next_cycle();
        memread = 1'b0; iord = 1'b0;
        sample();
        check("rd_mdr",     {24'd0, dut8.mdr_q}, 32'h5A);
        check("rd_pc_held", {24'd0, addr8},      32'h00);

        memwrite = 1'b1;
        #1;
        check("wr_req_we", {30'd0, req8, we8}, 32'b11);
        memwrite = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
